// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: reads ROM at pc, presents the instruction with a
// valid/ready handshake and pulses program-counter controls. Macro FETCH_COND_JUMP_EN enables OPC_JZ.
module fetch_controller #(
  parameter int unsigned          CNTR_WIDTH = 8,
  parameter int unsigned          OPC_WIDTH  = 4,
  parameter logic [OPC_WIDTH-1:0] OPC_JMP    = 4'hA,
  parameter logic [OPC_WIDTH-1:0] OPC_JZ     = 4'hB,
  parameter logic [OPC_WIDTH-1:0] OPC_HLT    = 4'hF
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [CNTR_WIDTH-1:0]           pc,
  output logic [CNTR_WIDTH-1:0]           rom_addr,
  output logic                            rom_rd,
  input  logic [OPC_WIDTH+CNTR_WIDTH-1:0] rom_q,
  input  logic                            zero_flag,
  input  logic                            resume,
  output logic [OPC_WIDTH+CNTR_WIDTH-1:0] instr,
  output logic                            instr_valid,
  input  logic                            instr_ready,
  output logic                            pc_ce,
  output logic                            pc_jmp,
  output logic [CNTR_WIDTH-1:0]           pc_target,
  output logic                            halted
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_WAIT    = 3'd2,
    S_PRESENT = 3'd3,
    S_HALT    = 3'd4
  } state_t;

  state_t               state;
  logic [OPC_WIDTH-1:0] opc;
  logic                 handshake;
  logic                 resume_step;
  logic                 take_jump;

  assign opc         = instr[OPC_WIDTH+CNTR_WIDTH-1:CNTR_WIDTH];
  assign handshake   = instr_valid & instr_ready;
  assign resume_step = (state == S_HALT) & resume;

`ifdef FETCH_COND_JUMP_EN
  assign take_jump = (opc == OPC_JMP) | ((opc == OPC_JZ) & zero_flag);
`else
  // JZ decodes as an ordinary opcode here, so the flag has no consumer.
  logic unused_jz;
  assign unused_jz = (opc == OPC_JZ) ^ zero_flag;
  assign take_jump = (opc == OPC_JMP);
`endif

  // Counter controls are single-cycle pulses derived from the handshake itself.
  assign pc_ce     = (handshake & (opc != OPC_HLT)) | resume_step;
  assign pc_jmp    = handshake & take_jump;
  assign pc_target = instr[CNTR_WIDTH-1:0];
  assign rom_addr  = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      instr       <= '0;
      instr_valid <= 1'b0;
      rom_rd      <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state  <= S_FETCH;
          rom_rd <= 1'b1;
        end
        S_FETCH: begin
          state  <= S_WAIT;
          rom_rd <= 1'b0;
        end
        S_WAIT: begin
          state       <= S_PRESENT;
          instr       <= rom_q;
          instr_valid <= 1'b1;
        end
        S_PRESENT: begin
          if (handshake) begin
            instr_valid <= 1'b0;
            if (opc == OPC_HLT) begin
              state  <= S_HALT;
              halted <= 1'b1;
            end else begin
              state  <= S_FETCH;
              rom_rd <= 1'b1;
            end
          end
        end
        S_HALT: begin
          if (resume) begin
            state  <= S_FETCH;
            halted <= 1'b0;
            rom_rd <= 1'b1;
          end
        end
        default: begin
          state       <= S_IDLE;
          instr_valid <= 1'b0;
          rom_rd      <= 1'b0;
          halted      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: ROM and program-counter models around the DUT, an
// instruction-level reference model in a negedge monitor, directed and random phases.
module tb_fetch_controller;

`ifdef FETCH_COND_JUMP_EN
  localparam bit COND = 1'b1;
`else
  localparam bit COND = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [7:0]  pc;
  logic [7:0]  rom_addr;
  logic        rom_rd;
  logic [11:0] rom_q;
  logic        zero_flag;
  logic        resume;
  logic [11:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        pc_ce;
  logic        pc_jmp;
  logic [7:0]  pc_target;
  logic        halted;

  logic [11:0] rom [256];

  int n_checks = 0;
  int n_fail   = 0;

  fetch_controller dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .rom_addr(rom_addr), .rom_rd(rom_rd),
    .rom_q(rom_q), .zero_flag(zero_flag), .resume(resume), .instr(instr),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .pc_ce(pc_ce),
    .pc_jmp(pc_jmp), .pc_target(pc_target), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment: synchronous ROM and the program counter driven by the DUT.
  always @(posedge clk) if (rom_rd) rom_q <= rom[rom_addr];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= 8'h00;
    else if (pc_ce) pc <= pc_jmp ? pc_target : pc + 8'h01;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Instruction-level reference: architectural pc, halt status and fetch timing.
  logic [7:0]  arch_pc;
  logic        in_halt, expect_rd, prev_rd, prev_valid;
  logic [11:0] prev_instr;
  int          since_rst, rd_age;

  always @(negedge clk) begin
    logic       hs, exp_ce, exp_jmp;
    logic [3:0] op;
    logic [7:0] opd;
    if (!rst_n) begin
      arch_pc = 8'h00; in_halt = 1'b0; expect_rd = 1'b0; prev_rd = 1'b0;
      prev_valid = 1'b0; prev_instr = '0; since_rst = 0; rd_age = 99;
    end else begin
      since_rst++;
      hs  = instr_valid && instr_ready;
      op  = instr[11:8];
      opd = instr[7:0];
      check_eq("rom_addr_eq_pc", rom_addr, pc);
      if (since_rst == 1) check_eq("idle_no_rd", rom_rd, 0);
      if (since_rst == 2) check_eq("first_fetch", rom_rd, 1);
      if (expect_rd) check_eq("refetch", rom_rd, 1);
      if (prev_rd) check_eq("rd_single_cycle", rom_rd, 0);
      if (rom_rd) begin
        rd_age = 0;
        check_eq("fetch_addr", rom_addr, arch_pc);
      end else if (rd_age < 99) rd_age++;
      if (instr_valid && !prev_valid) begin
        check_eq("fetch_latency", rd_age, 2);
        check_eq("instr_data", instr, rom[arch_pc]);
      end
      if (instr_valid && prev_valid) check_eq("instr_stable", instr, prev_instr);
      check_eq("halted", halted, in_halt);
      if (in_halt) check_eq("halt_quiet", {rom_rd, instr_valid}, 0);

      exp_ce = 1'b0; exp_jmp = 1'b0;
      if (hs) begin
        case (op)
          4'hF:    begin exp_ce = 1'b0; exp_jmp = 1'b0; end
          4'hA:    begin exp_ce = 1'b1; exp_jmp = 1'b1; end
          4'hB:    begin exp_ce = 1'b1; exp_jmp = COND && zero_flag; end
          default: begin exp_ce = 1'b1; exp_jmp = 1'b0; end
        endcase
      end else if (in_halt && resume) exp_ce = 1'b1;
      check_eq("pc_ce", pc_ce, exp_ce);
      check_eq("pc_jmp", pc_jmp, exp_jmp);
      if (exp_jmp) check_eq("pc_target", pc_target, opd);

      expect_rd = 1'b0;
      if (hs) begin
        if (op == 4'hF) in_halt = 1'b1;
        else begin
          arch_pc   = exp_jmp ? opd : arch_pc + 8'h01;
          expect_rd = 1'b1;
        end
      end else if (in_halt && resume) begin
        in_halt   = 1'b0;
        arch_pc   = arch_pc + 8'h01;
        expect_rd = 1'b1;
      end
      prev_rd = rom_rd; prev_valid = instr_valid; prev_instr = instr;
    end
  end

  task automatic wait_valid(input string tag);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!instr_valid && n < 20);
    if (!instr_valid) check_eq({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    logic [7:0] resume_pc;
    rst_n = 1'b0; instr_ready = 1'b1; zero_flag = 1'b0; resume = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 12'h000;
    rom[8'h00] = 12'h012; rom[8'h01] = 12'hA40; rom[8'h40] = 12'h355;
    rom[8'h41] = 12'hB10; rom[8'h10] = 12'hB30; rom[8'h42] = 12'hB30;
    rom[8'h11] = 12'hF00; rom[8'h43] = 12'hF00;
    rom[8'h12] = 12'h777; rom[8'h44] = 12'h777;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_instr", instr, 0);
    check_eq("rst_valid", instr_valid, 0);
    check_eq("rst_rd", rom_rd, 0);
    check_eq("rst_ctl", {pc_ce, pc_jmp}, 0);
    check_eq("rst_halted", halted, 0);
    #1; rst_n = 1'b1;

    // First instruction: read in cycle 1, presented in cycle 3.
    @(posedge clk); #1;
    check_eq("c1_rd", {rom_rd, rom_addr}, {1'b1, 8'h00});
    @(posedge clk); #1;
    check_eq("c2_rd", rom_rd, 0);
    @(posedge clk); #1;
    check_eq("c3_valid", instr_valid, 1);
    check_eq("c3_instr", instr, 12'h012);
    check_eq("c3_ctl", {pc_ce, pc_jmp}, 2'b10);

    wait_valid("jmp");
    check_eq("jmp_instr", instr, 12'hA40);
    check_eq("jmp_ctl", {pc_ce, pc_jmp}, 2'b11);
    check_eq("jmp_target", pc_target, 8'h40);
    @(posedge clk); #1;
    check_eq("jmp_fetch", {rom_rd, rom_addr}, {1'b1, 8'h40});
    instr_ready = 1'b0;

    wait_valid("stall");
    for (int i = 0; i < 5; i++) begin
      check_eq("stall_valid", instr_valid, 1);
      check_eq("stall_instr", instr, 12'h355);
      check_eq("stall_ce", pc_ce, 0);
      check_eq("stall_rd", rom_rd, 0);
      @(posedge clk); #1;
    end
    zero_flag = 1'b1; instr_ready = 1'b1;
    #1;
    check_eq("stall_release_ce", pc_ce, 1);

    wait_valid("jz1");
    check_eq("jz1_instr", instr, 12'hB10);
    check_eq("jz1_ctl", {pc_ce, pc_jmp}, {1'b1, COND});
    @(posedge clk); #1;
    zero_flag = 1'b0;
    wait_valid("jz0");
    check_eq("jz0_instr", instr, 12'hB30);
    check_eq("jz0_ctl", {pc_ce, pc_jmp}, 2'b10);

    wait_valid("hlt");
    check_eq("hlt_instr", instr, 12'hF00);
    check_eq("hlt_ctl", {pc_ce, pc_jmp}, 2'b00);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check_eq("halt_flag", halted, 1);
      check_eq("halt_no_rd", {rom_rd, instr_valid}, 0);
    end
    resume = 1'b1;
    #1;
    check_eq("resume_ctl", {pc_ce, pc_jmp}, 2'b10);
    resume_pc = COND ? 8'h12 : 8'h44;
    @(posedge clk); #1;
    resume = 1'b0;
    check_eq("resume_halted", halted, 0);
    check_eq("resume_fetch", {rom_rd, rom_addr}, {1'b1, resume_pc});

    // Reset asserted while the ROM read is in flight.
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_outs", {instr, instr_valid, rom_rd, pc_ce, pc_jmp, halted}, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("post_rst_fetch", {rom_rd, rom_addr}, {1'b1, 8'h00});

    // Random program with random handshake, flag and resume activity.
    @(posedge clk); #2;
    rst_n = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 12'($urandom);
    rom[8'h00] = 12'hBFE; rom[8'hFE] = 12'h1AB; rom[8'hFF] = 12'h2CD;
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #2;
      instr_ready = ($urandom % 4) != 0;
      zero_flag   = 1'($urandom);
      resume      = ($urandom % 4) == 0;
    end
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
